frog_motion_ctrl: RTL and testbench
===================================

Name: frog_motion_ctrl

Overview:
Parametrised successor to the player-movement block. It tracks the frog on a configurable tile grid and applies press/hold auto-repeat timing. It also manages lives, score, level-up, a timed respawn with blink, and game-over. It sits between the debounced switch inputs, collision detect and the VGA sprite renderer.

Parameters:
TILE_SIZE, 32, pixel size of one grid tile (power of two)
GRID_COLS, 20, playfield width in tiles
GRID_ROWS, 15, playfield height in tiles
START_COL, 10, respawn column
START_ROW, 12, respawn row
GOAL_ROW, 0, row that scores when entered
REPEAT_DELAY, 6250000, hold cycles before first auto-repeat
MOVE_DELAY, 3125000, cycles between auto-repeat moves
RESPAWN_CYCLES, 25000000, length of death/respawn phase
BLINK_DIV, 3125000, half-period of the respawn blink
LIVES_INI, 3, lives at game start (≥1)
SCORE_W, 4, score width
LIVES_W, 2, lives width (must hold LIVES_INI)

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  asynchronous active-low reset
i_Game_Active  in  1  game running
i_Frog_Up  in  1  direction request
i_Frog_Dn  in  1  direction request
i_Frog_Lt  in  1  direction request
i_Frog_Rt  in  1  direction request
i_Has_Collided  in  1  frog hit hazard (level)
o_Frog_X  out  10  left pixel = col*TILE_SIZE
o_Frog_Y  out  9  top pixel = row*TILE_SIZE
o_Draw_Frog  out  1  sprite visible
o_Level_Up  out  1  one-cycle pulse on goal
o_Score  out  SCORE_W  goals reached, saturating
o_Lives  out  LIVES_W  remaining lives
o_Game_Over  out  1  lives exhausted

Behaviour:
- Reset (async, i_Rst_L=0): state IDLE; col/row=START; score=0; lives=LIVES_INI; o_Level_Up=0; o_Game_Over=0; o_Draw_Frog=0; all timers=0. Outputs are registered.
- Valid request: exactly one of the four direction inputs is high (one-hot). Zero or multiple high means no request, and the hold timer clears.
- FSM states: IDLE, READY, HOLD, DYING, OVER.
- IDLE: o_Draw_Frog=0. On i_Game_Active=1 the block reinitialises col/row, score=0 and lives=LIVES_INI, then goes to READY.
- READY: o_Draw_Frog=1.
  - When a valid request is seen, the move applies on the next clock edge.
  - Hold timer loads REPEAT_DELAY; go to HOLD.
- HOLD, request held with the same direction:
  - When the timer reaches 0, move again and reload MOVE_DELAY.
- HOLD, request released, changed or invalid:
  - Return to READY with no move that cycle.
  - A new valid request is accepted the following cycle.
- Move rules:
  - Up is allowed if row>0.
  - Dn is allowed if row<GRID_ROWS-1.
  - Lt is allowed if col>0.
  - Rt is allowed if col<GRID_COLS-1.
  - A blocked move leaves position unchanged but still consumes the press/timer; there is no wrap-around.
- Goal: if a move lands on row==GOAL_ROW:
  - Position resets to START in that same update; the frog never displays at GOAL_ROW.
  - Score increments, saturating at 2^SCORE_W-1.
  - o_Level_Up=1 for exactly one cycle.
  - FSM returns to READY.
- Collision, evaluated in READY/HOLD with i_Has_Collided=1:
  - Lives decrement by 1.
  - If the result is 0: go to OVER.
  - Otherwise go to DYING and load the respawn timer with RESPAWN_CYCLES.
  - Collision has priority over a same-cycle move or goal; position stays unchanged.
- DYING:
  - Direction inputs and i_Has_Collided are ignored.
  - o_Draw_Frog toggles every BLINK_DIV cycles, starting at 0.
  - At timer expiry: position=START, o_Draw_Frog=1, go to READY. A request still held at that point is treated as new.
- OVER: o_Game_Over=1, o_Draw_Frog=0; position and score are held. Leaves only via i_Game_Active=0 → IDLE.
- i_Game_Active=0 in any state: next state IDLE and all timers clear. Score, lives and position hold until re-entry.
- Timers count down, sized with $clog2 of the largest delay; they saturate at 0.
- X/Y widths: o_Frog_X=col*TILE_SIZE and o_Frog_Y=row*TILE_SIZE, truncated to 10 and 9 bits. Parameters must keep the grid within 640×480.

Test Plan:
Bench overrides: MOVE_DELAY=4, REPEAT_DELAY=10, RESPAWN_CYCLES=16, BLINK_DIV=4, TILE_SIZE=32, START=(10,12).
1. Reset, then i_Game_Active=1, then pulse Up for 1 cycle → Y goes 384→352 exactly one cycle after the press; no further move.
2. Hold Rt for 30 cycles from col 10 → moves at t=1, 11, 15, 19, 23, 27; final X=(10+6)*32=512. Holding Rt at col 19 → X stays 608.
3. Step Up 12 times → 12th move sets X=320, Y=384, score=1, o_Level_Up high for exactly 1 cycle.
4. Assert i_Has_Collided together with Up → no move; lives 3→2; o_Draw_Frog blinks with period 8 for 16 cycles; then the frog is at (320,384) and READY. Inputs during DYING have no effect.
5. Three collisions → lives=0, o_Game_Over=1, o_Draw_Frog=0. Drop then raise i_Game_Active → lives=3, score=0, o_Game_Over=0.
6. Up+Lt held together → no movement. Assert i_Rst_L=0 mid-HOLD (asynchronous, no clock edge) → outputs return to reset values immediately.

Source files
------------

// File: rtl/frog_motion_ctrl_if.sv
// Frog motion controller bus: switch, collision
// and game-state inputs, sprite/score outputs.
interface frog_motion_ctrl_if #(
  parameter int SCORE_W = 4,
  parameter int LIVES_W = 2
);
  logic               i_Game_Active;
  logic               i_Frog_Up;
  logic               i_Frog_Dn;
  logic               i_Frog_Lt;
  logic               i_Frog_Rt;
  logic               i_Has_Collided;
  logic [9:0]         o_Frog_X;
  logic [8:0]         o_Frog_Y;
  logic               o_Draw_Frog;
  logic               o_Level_Up;
  logic [SCORE_W-1:0] o_Score;
  logic [LIVES_W-1:0] o_Lives;
  logic               o_Game_Over;

  modport master (
    output i_Game_Active,
    output i_Frog_Up,
    output i_Frog_Dn,
    output i_Frog_Lt,
    output i_Frog_Rt,
    output i_Has_Collided,
    input  o_Frog_X,
    input  o_Frog_Y,
    input  o_Draw_Frog,
    input  o_Level_Up,
    input  o_Score,
    input  o_Lives,
    input  o_Game_Over
  );

  modport slave (
    input  i_Game_Active,
    input  i_Frog_Up,
    input  i_Frog_Dn,
    input  i_Frog_Lt,
    input  i_Frog_Rt,
    input  i_Has_Collided,
    output o_Frog_X,
    output o_Frog_Y,
    output o_Draw_Frog,
    output o_Level_Up,
    output o_Score,
    output o_Lives,
    output o_Game_Over
  );
endinterface

// File: rtl/frog_motion_ctrl.sv
// Frog grid motion with press/hold auto-repeat,
// lives, score, goal level-up and blinking respawn.
module frog_motion_ctrl #(
  parameter int TILE_SIZE      = 32,
  parameter int GRID_COLS      = 20,
  parameter int GRID_ROWS      = 15,
  parameter int START_COL      = 10,
  parameter int START_ROW      = 12,
  parameter int GOAL_ROW       = 0,
  parameter int REPEAT_DELAY   = 6250000,
  parameter int MOVE_DELAY     = 3125000,
  parameter int RESPAWN_CYCLES = 25000000,
  parameter int BLINK_DIV      = 3125000,
  parameter int LIVES_INI      = 3,
  parameter int SCORE_W        = 4,
  parameter int LIVES_W        = 2
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  frog_motion_ctrl_if.slave  if_Frog
);

  localparam int COL_W =
    (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
  localparam int ROW_W =
    (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
  localparam int TILE_SH = $clog2(TILE_SIZE);
  localparam int MAX_A =
    (REPEAT_DELAY > MOVE_DELAY) ?
    REPEAT_DELAY : MOVE_DELAY;
  localparam int MAX_B =
    (RESPAWN_CYCLES > BLINK_DIV) ?
    RESPAWN_CYCLES : BLINK_DIV;
  localparam int MAX_D =
    (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TMR_W = $clog2(MAX_D + 1);

  localparam logic [COL_W-1:0] C_START =
    COL_W'(START_COL);
  localparam logic [ROW_W-1:0] R_START =
    ROW_W'(START_ROW);
  localparam logic [ROW_W-1:0] R_GOAL =
    ROW_W'(GOAL_ROW);
  localparam logic [COL_W-1:0] C_LAST =
    COL_W'(GRID_COLS - 1);
  localparam logic [ROW_W-1:0] R_LAST =
    ROW_W'(GRID_ROWS - 1);
  localparam logic [TMR_W-1:0] T_ONE =
    TMR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_HOLD,
    S_DYING,
    S_OVER
  } state_t;

  state_t             r_state;
  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic [3:0]         r_dir;
  logic [TMR_W-1:0]   r_hold;
  logic [TMR_W-1:0]   r_resp;
  logic [TMR_W-1:0]   r_blink;
  logic               r_draw;
  logic               r_lvl;
  logic [SCORE_W-1:0] r_score;
  logic [LIVES_W-1:0] r_lives;
  logic               r_over;

  logic [3:0]         w_dir;
  logic               w_valid;
  logic               w_goal;
  logic [COL_W-1:0]   w_nxt_col;
  logic [ROW_W-1:0]   w_nxt_row;
  logic [SCORE_W-1:0] w_score_inc;

  assign w_dir = {if_Frog.i_Frog_Up,
                  if_Frog.i_Frog_Dn,
                  if_Frog.i_Frog_Lt,
                  if_Frog.i_Frog_Rt};
  assign w_valid = $onehot(w_dir);

  // Target tile of the current request; blocked
  // directions leave the position where it is.
  always_comb begin
    w_nxt_col = r_col;
    w_nxt_row = r_row;
    if (w_valid) begin
      unique case (1'b1)
        if_Frog.i_Frog_Up:
          if (r_row != '0)
            w_nxt_row = r_row - ROW_W'(1);
        if_Frog.i_Frog_Dn:
          if (r_row < R_LAST)
            w_nxt_row = r_row + ROW_W'(1);
        if_Frog.i_Frog_Lt:
          if (r_col != '0)
            w_nxt_col = r_col - COL_W'(1);
        if_Frog.i_Frog_Rt:
          if (r_col < C_LAST)
            w_nxt_col = r_col + COL_W'(1);
        default: ;
      endcase
    end
  end

  assign w_goal = w_valid &&
                  (w_nxt_row != r_row) &&
                  (w_nxt_row == R_GOAL);

  assign w_score_inc = (r_score == '1) ?
                       r_score :
                       r_score + SCORE_W'(1);

  // Main FSM with registered sprite/game outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state <= S_IDLE;
      r_col   <= C_START;
      r_row   <= R_START;
      r_dir   <= '0;
      r_hold  <= '0;
      r_resp  <= '0;
      r_blink <= '0;
      r_draw  <= 1'b0;
      r_lvl   <= 1'b0;
      r_score <= '0;
      r_lives <= LIVES_W'(LIVES_INI);
      r_over  <= 1'b0;
    end else begin
      r_lvl <= 1'b0;
      if (!if_Frog.i_Game_Active) begin
        r_state <= S_IDLE;
        r_hold  <= '0;
        r_resp  <= '0;
        r_blink <= '0;
        r_draw  <= 1'b0;
        r_over  <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_col   <= C_START;
            r_row   <= R_START;
            r_score <= '0;
            r_lives <= LIVES_W'(LIVES_INI);
            r_draw  <= 1'b1;
            r_over  <= 1'b0;
            r_state <= S_READY;
          end
          S_READY, S_HOLD: begin
            if (if_Frog.i_Has_Collided) begin
              r_lives <= r_lives - LIVES_W'(1);
              r_hold  <= '0;
              r_draw  <= 1'b0;
              if (r_lives <= LIVES_W'(1)) begin
                r_over  <= 1'b1;
                r_state <= S_OVER;
              end else begin
                r_resp  <= TMR_W'(RESPAWN_CYCLES);
                r_blink <= TMR_W'(BLINK_DIV);
                r_state <= S_DYING;
              end
            end else if (r_state == S_READY) begin
              if (w_valid) begin
                r_dir   <= w_dir;
                r_hold  <= TMR_W'(REPEAT_DELAY);
                r_state <= S_HOLD;
                r_col   <= w_goal ? C_START : w_nxt_col;
                r_row   <= w_goal ? R_START : w_nxt_row;
                if (w_goal) begin
                  r_score <= w_score_inc;
                  r_lvl   <= 1'b1;
                  r_hold  <= '0;
                  r_state <= S_READY;
                end
              end else begin
                r_hold <= '0;
              end
            end else if (!w_valid ||
                         (w_dir != r_dir)) begin
              r_hold  <= '0;
              r_state <= S_READY;
            end else if (r_hold <= T_ONE) begin
              r_hold <= TMR_W'(MOVE_DELAY);
              r_col  <= w_goal ? C_START : w_nxt_col;
              r_row  <= w_goal ? R_START : w_nxt_row;
              if (w_goal) begin
                r_score <= w_score_inc;
                r_lvl   <= 1'b1;
                r_hold  <= '0;
                r_state <= S_READY;
              end
            end else begin
              r_hold <= r_hold - T_ONE;
            end
          end
          S_DYING: begin
            if (r_resp <= T_ONE) begin
              r_resp  <= '0;
              r_blink <= '0;
              r_col   <= C_START;
              r_row   <= R_START;
              r_draw  <= 1'b1;
              r_state <= S_READY;
            end else begin
              r_resp <= r_resp - T_ONE;
              if (r_blink <= T_ONE) begin
                r_draw  <= ~r_draw;
                r_blink <= TMR_W'(BLINK_DIV);
              end else begin
                r_blink <= r_blink - T_ONE;
              end
            end
          end
          S_OVER: begin
            r_over <= 1'b1;
            r_draw <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign if_Frog.o_Frog_X    = 10'(r_col) << TILE_SH;
  assign if_Frog.o_Frog_Y    = 9'(r_row) << TILE_SH;
  assign if_Frog.o_Draw_Frog = r_draw;
  assign if_Frog.o_Level_Up  = r_lvl;
  assign if_Frog.o_Score     = r_score;
  assign if_Frog.o_Lives     = r_lives;
  assign if_Frog.o_Game_Over = r_over;

endmodule

// File: tb/tb_frog_motion_ctrl.sv
// Directed scoreboard bench for frog_motion_ctrl
// with short timer overrides.
module tb_frog_motion_ctrl;

  logic clk;
  logic rst_n;

  frog_motion_ctrl_if #(
    .SCORE_W(4),
    .LIVES_W(2)
  ) bus ();

  frog_motion_ctrl #(
    .TILE_SIZE(32),
    .GRID_COLS(20),
    .GRID_ROWS(15),
    .START_COL(10),
    .START_ROW(12),
    .GOAL_ROW(0),
    .REPEAT_DELAY(10),
    .MOVE_DELAY(4),
    .RESPAWN_CYCLES(16),
    .BLINK_DIV(4),
    .LIVES_INI(3),
    .SCORE_W(4),
    .LIVES_W(2)
  ) dut (
    .i_Clk(clk),
    .i_Rst_L(rst_n),
    .if_Frog(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int draw;
    int lvl;
    int score;
    int lives;
    int over;
  } snap_t;

  snap_t sb[$];
  int n_vec;
  int n_err;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cmp(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic push(input int col, input int row,
                      input int draw, input int lvl,
                      input int score, input int lives,
                      input int over);
    snap_t e;
    e.x = col * 32;
    e.y = row * 32;
    e.draw = draw;
    e.lvl = lvl;
    e.score = score;
    e.lives = lives;
    e.over = over;
    sb.push_back(e);
  endtask

  task automatic check(input string tag);
    snap_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s observed=empty expected=entry",
             tag);
    end else begin
      e = sb.pop_front();
      cmp({tag, ".x"}, 32'(bus.o_Frog_X), e.x);
      cmp({tag, ".y"}, 32'(bus.o_Frog_Y), e.y);
      cmp({tag, ".draw"}, 32'(bus.o_Draw_Frog),
          e.draw);
      cmp({tag, ".lvl"}, 32'(bus.o_Level_Up),
          e.lvl);
      cmp({tag, ".score"}, 32'(bus.o_Score),
          e.score);
      cmp({tag, ".lives"}, 32'(bus.o_Lives),
          e.lives);
      cmp({tag, ".over"}, 32'(bus.o_Game_Over),
          e.over);
    end
  endtask

  task automatic step_chk(input string tag,
                          input int col, input int row,
                          input int draw, input int lvl,
                          input int score, input int lives,
                          input int over);
    push(col, row, draw, lvl, score, lives, over);
    tick(1);
    check(tag);
  endtask

  task automatic now_chk(input string tag,
                         input int col, input int row,
                         input int draw, input int lvl,
                         input int score, input int lives,
                         input int over);
    push(col, row, draw, lvl, score, lives, over);
    check(tag);
  endtask

  task automatic dirs(input logic up, input logic dn,
                      input logic lt, input logic rt);
    bus.i_Frog_Up = up;
    bus.i_Frog_Dn = dn;
    bus.i_Frog_Lt = lt;
    bus.i_Frog_Rt = rt;
  endtask

  function automatic int moves_at(input int t);
    int n;
    n = (t >= 1) ? 1 : 0;
    if (t >= 11) n += (t - 11) / 4 + 1;
    return n;
  endfunction

  initial begin
    int col;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.i_Game_Active = 1'b0;
    bus.i_Has_Collided = 1'b0;
    dirs(0, 0, 0, 0);
    tick(2);
    now_chk("reset", 10, 12, 0, 0, 0, 3, 0);
    rst_n = 1'b1;
    step_chk("idle", 10, 12, 0, 0, 0, 3, 0);
    bus.i_Game_Active = 1'b1;
    step_chk("start", 10, 12, 1, 0, 0, 3, 0);

    dirs(1, 0, 0, 0);
    step_chk("up_pulse", 10, 11, 1, 0, 0, 3, 0);
    dirs(0, 0, 0, 0);
    step_chk("up_rel", 10, 11, 1, 0, 0, 3, 0);
    tick(3);
    now_chk("up_quiet", 10, 11, 1, 0, 0, 3, 0);

    dirs(0, 0, 0, 1);
    for (int t = 1; t <= 30; t++) begin
      col = 10 + moves_at(t);
      step_chk($sformatf("rt_hold%0d", t),
               col, 11, 1, 0, 0, 3, 0);
    end
    dirs(0, 0, 0, 0);
    step_chk("rt_rel", 16, 11, 1, 0, 0, 3, 0);
    dirs(0, 0, 0, 1);
    for (int t = 1; t <= 20; t++) begin
      col = 16 + moves_at(t);
      if (col > 19) col = 19;
      step_chk($sformatf("rt_edge%0d", t),
               col, 11, 1, 0, 0, 3, 0);
    end
    dirs(0, 0, 0, 0);
    step_chk("rt_edge_rel", 19, 11, 1, 0, 0, 3, 0);

    bus.i_Game_Active = 1'b0;
    step_chk("drop", 19, 11, 0, 0, 0, 3, 0);
    bus.i_Game_Active = 1'b1;
    step_chk("reinit", 10, 12, 1, 0, 0, 3, 0);
    for (int i = 1; i <= 12; i++) begin
      dirs(1, 0, 0, 0);
      if (i < 12)
        step_chk($sformatf("step%0d", i),
                 10, 12 - i, 1, 0, 0, 3, 0);
      else
        step_chk("goal", 10, 12, 1, 1, 1, 3, 0);
      dirs(0, 0, 0, 0);
      step_chk($sformatf("step_rel%0d", i),
               10, (i < 12) ? 12 - i : 12,
               1, 0, (i < 12) ? 0 : 1, 3, 0);
    end

    dirs(1, 0, 0, 0);
    bus.i_Has_Collided = 1'b1;
    step_chk("hit1", 10, 12, 0, 0, 1, 2, 0);
    dirs(0, 1, 0, 0);
    for (int k = 1; k <= 15; k++) begin
      if (k == 11) begin
        dirs(0, 0, 0, 0);
        bus.i_Has_Collided = 1'b0;
      end
      step_chk($sformatf("blink%0d", k), 10, 12,
               (k / 4) % 2, 0, 1, 2, 0);
    end
    step_chk("respawn", 10, 12, 1, 0, 1, 2, 0);
    step_chk("ready2", 10, 12, 1, 0, 1, 2, 0);

    bus.i_Has_Collided = 1'b1;
    step_chk("hit2", 10, 12, 0, 0, 1, 1, 0);
    bus.i_Has_Collided = 1'b0;
    tick(15);
    step_chk("respawn2", 10, 12, 1, 0, 1, 1, 0);
    bus.i_Has_Collided = 1'b1;
    step_chk("hit3", 10, 12, 0, 0, 1, 0, 1);
    bus.i_Has_Collided = 1'b0;
    tick(3);
    now_chk("over", 10, 12, 0, 0, 1, 0, 1);
    bus.i_Game_Active = 1'b0;
    tick(1);
    bus.i_Game_Active = 1'b1;
    step_chk("restart", 10, 12, 1, 0, 0, 3, 0);

    dirs(1, 0, 1, 0);
    for (int i = 1; i <= 5; i++)
      step_chk($sformatf("multi%0d", i),
               10, 12, 1, 0, 0, 3, 0);
    dirs(0, 0, 0, 0);
    step_chk("multi_rel", 10, 12, 1, 0, 0, 3, 0);
    dirs(0, 0, 0, 1);
    step_chk("hold_in", 11, 12, 1, 0, 0, 3, 0);
    tick(3);
    now_chk("hold_mid", 11, 12, 1, 0, 0, 3, 0);
    #2;
    rst_n = 1'b0;
    #1;
    now_chk("async_rst", 10, 12, 0, 0, 0, 3, 0);
    step_chk("rst_held", 10, 12, 0, 0, 0, 3, 0);
    rst_n = 1'b1;
    dirs(0, 0, 0, 0);
    tick(1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
